// File: rtl/fifo_rd_stream.sv
// Read-side master for fifo_asynchronous: pops on !empty, absorbs the 1-cycle read latency in a
// 2-entry skid buffer and emits a valid/ready stream with o_last framing. Optional stats: FIFO_RD_STATS_EN.
module fifo_rd_stream #(
  parameter int SIZE_DATA = 8,
  parameter int BURST_LEN = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_fifo_rd_en,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last,
  input  logic                 i_flush
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]          o_word_cnt,
  output logic [15:0]          o_stall_cnt
`endif
);
  localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

  logic [1:0][SIZE_DATA-1:0] buf_q, buf_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic [1:0]                occ_q, occ_d;
  logic                      inflight_q, inflight_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      pop_out, capture, at_last;
  logic [2:0]                level;

  assign pop_out = o_valid && i_ready;
  assign capture = inflight_q;
  assign at_last = (cnt_q == LAST_CNT);
  // Occupancy as it will stand after this edge, counting the word still in flight.
  assign level   = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop_out};

  // Gated by reset so a non-empty FIFO is never popped while the block is held in reset.
  assign o_fifo_rd_en = i_rst_n && !i_fifo_empty && !i_flush && (level < 3'd2);

  assign o_valid = (occ_q != 2'd0);
  assign o_data  = buf_q[rd_ptr_q];
  assign o_last  = o_valid && at_last;

  always_comb begin
    buf_d      = buf_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    cnt_d      = cnt_q;
    inflight_d = o_fifo_rd_en;
    if (i_flush) begin
      // Buffered words are dropped, but a word already leaving the FIFO is kept.
      rd_ptr_d = 1'b0;
      wr_ptr_d = capture;
      occ_d    = {1'b0, capture};
      cnt_d    = '0;
      if (capture) buf_d[0] = i_fifo_data;
    end else begin
      if (capture) begin
        buf_d[wr_ptr_q] = i_fifo_data;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (pop_out) begin
        rd_ptr_d = !rd_ptr_q;
        cnt_d    = at_last ? 16'd0 : cnt_q + 16'd1;
      end
      occ_d = occ_q + {1'b0, capture} - {1'b0, pop_out};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      buf_q      <= buf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (i_flush) begin
      word_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (pop_out) word_cnt_d = word_cnt_q + 32'd1;
      if (o_valid && !i_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_word_cnt  = word_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model with registered read, stream scoreboard
// monitor, and directed/random scenario tasks. Stats checks compile in with FIFO_RD_STATS_EN.
module tb_fifo_rd_stream;
  localparam int SD = 8;
  localparam int BL = 16;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          o_fifo_rd_en;
  logic [SD-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [SD-1:0] o_data;
  logic          o_last;
  logic          i_flush = 1'b0;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]   o_word_cnt;
  logic [15:0]   o_stall_cnt;
`endif

  fifo_rd_stream #(.SIZE_DATA(SD), .BURST_LEN(BL)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_fifo_rd_en(o_fifo_rd_en), .i_fifo_data(fifo_data),
    .i_fifo_empty(fifo_empty), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .i_flush(i_flush)
`ifdef FIFO_RD_STATS_EN
    , .o_word_cnt(o_word_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [SD-1:0] fq[$];    // words sitting in the FIFO
  logic [SD-1:0] pend[$];  // words popped from the FIFO but not yet accepted downstream
  bit            popped_last;
  int            pop_total = 0;
  int            xfer = 0;
  bit            hold_prev = 0;
  logic [SD-1:0] hd, popw, expw, keepw;
  logic          hl, expl;

  // FIFO model: registered read, data appears the cycle after the pop.
  always @(posedge i_clk) begin
    popped_last = 1'b0;
    if (i_rst_n && o_fifo_rd_en) begin
      if (fq.size() == 0) begin
        n_err++;
        $display("FAIL overread: rd_en=1 with %0d words in FIFO, required a non-empty FIFO", fq.size());
      end else begin
        popw = fq.pop_front();
        fifo_data <= popw;
        pend.push_back(popw);
        popped_last = 1'b1;
        pop_total++;
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Stream scoreboard: in-order delivery, burst framing, stability under backpressure.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold_prev = 0;
      xfer = 0;
    end else begin
      n_cmp++;
      if (o_fifo_rd_en && fifo_empty) begin
        n_err++;
        $display("FAIL rd_en_on_empty: rd_en=%0b while empty=%0b, required rd_en=0", o_fifo_rd_en, fifo_empty);
      end
      if (hold_prev) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== hd || o_last !== hl) begin
          n_err++;
          $display("FAIL hold: valid=%0b data=%02h last=%0b, required valid=1 data=%02h last=%0b",
                   o_valid, o_data, o_last, hd, hl);
        end
      end
      if (o_valid && i_ready) begin
        n_cmp++;
        if (pend.size() == 0) begin
          n_err++;
          $display("FAIL spurious: transfer data=%02h with no word outstanding", o_data);
        end else begin
          expw = pend.pop_front();
          expl = ((xfer % BL) == BL - 1);
          if (o_data !== expw || o_last !== expl) begin
            n_err++;
            $display("FAIL stream: data=%02h last=%0b, required data=%02h last=%0b (xfer %0d)",
                     o_data, o_last, expw, expl, xfer);
          end
        end
        xfer++;
      end
      hold_prev = o_valid && !i_ready && !i_flush;
      hd = o_data;
      hl = o_last;
      if (i_flush) begin
        if (popped_last && pend.size() > 0) begin
          keepw = pend[pend.size()-1];
          pend.delete();
          pend.push_back(keepw);
        end else pend.delete();
        xfer = 0;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [SD-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    push(8'hAA);
    repeat (3) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_fifo_rd_en, o_valid, o_data, o_last} !== '0) begin
      n_err++;
      $display("FAIL reset_out: rd_en=%0b valid=%0b data=%02h last=%0b, required all 0",
               o_fifo_rd_en, o_valid, o_data, o_last);
    end
    fq.delete();
    fifo_empty = 1'b1;
    step();
    i_rst_n = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_fifo_rd_en !== 1'b0 || o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle: rd_en=%0b valid=%0b, required 0/0", o_fifo_rd_en, o_valid);
      end
    end
    step();
  endtask

  task automatic test_fill_drain();
    int t;
    i_ready = 1'b1;
    for (int i = 0; i < 32; i++) push(8'(i));
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!o_valid && t < 10);
    n_cmp++;
    if (t != 3) begin
      n_err++;
      $display("FAIL fill_latency: first valid at negedge %0d, required 3", t);
    end
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== 8'(k) || o_last !== ((k % BL) == BL - 1)) begin
        n_err++;
        $display("FAIL fill_drain: cycle %0d valid=%0b data=%02h last=%0b, required 1/%02h/%0b",
                 k, o_valid, o_data, o_last, 8'(k), ((k % BL) == BL - 1));
      end
      @(negedge i_clk);
    end
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drained: valid=%0b, required 0", o_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    int p0, got;
    i_ready = 1'b0;
    p0 = pop_total;
    for (int i = 0; i < 5; i++) push(8'(i));
    repeat (10) begin
      @(negedge i_clk);
      if (o_valid) begin
        n_cmp++;
        if (o_data !== 8'h00) begin
          n_err++;
          $display("FAIL bp_head: data=%02h, required 00", o_data);
        end
      end
    end
    n_cmp++;
    if (pop_total - p0 > 2 || o_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_pops: pops=%0d valid=%0b, required <=2 pops and valid=1", pop_total - p0, o_valid);
    end
    step();
    i_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge i_clk);
      if (o_valid && i_ready) begin
        n_cmp++;
        if (o_data !== 8'(got)) begin
          n_err++;
          $display("FAIL bp_order: word %0d data=%02h, required %02h", got, o_data, 8'(got));
        end
        got++;
      end
    end
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (got != 5 || pend.size() != 0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_count: got=%0d outstanding=%0d valid=%0b, required 5/0/0", got, pend.size(), o_valid);
    end
    step();
  endtask

  task automatic test_empty_edge();
    i_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      push(8'h40 + 8'(w));
      for (int n = 0; n < 3; n++) begin
        @(negedge i_clk);
        n_cmp++;
        if (o_valid !== (n == 2) || (n == 2 && o_data !== 8'h40 + 8'(w))) begin
          n_err++;
          $display("FAIL empty_edge: word %0d negedge %0d valid=%0b data=%02h, required valid=%0b data=%02h",
                   w, n, o_valid, o_data, (n == 2), 8'h40 + 8'(w));
        end
      end
      @(posedge i_clk);
      repeat (4) @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_flush();
    int got;
    i_ready = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
    repeat (12) step();
    i_ready = 1'b0;
    for (int i = 0; i < 20; i++) push(8'hA0 + 8'(i));
    repeat (6) step();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 8'hA0) begin
      n_err++;
      $display("FAIL flush_setup: valid=%0b data=%02h, required 1/A0", o_valid, o_data);
    end
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_valid: valid=%0b, required 0", o_valid);
    end
    got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      if (o_valid && i_ready) begin
        n_cmp++;
        if (o_data !== 8'hA2 + 8'(got) || o_last !== (got == 15)) begin
          n_err++;
          $display("FAIL flush_restart: word %0d data=%02h last=%0b, required %02h/%0b",
                   got, o_data, o_last, 8'hA2 + 8'(got), (got == 15));
        end
        got++;
      end
      @(negedge i_clk);
    end
    n_cmp++;
    if (got != 16) begin
      n_err++;
      $display("FAIL flush_timeout: %0d words after flush, required 16", got);
    end
    repeat (8) step();
  endtask

  task automatic test_random();
    int c;
    for (int k = 0; k < 3000; k++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      step();
    end
    i_flush = 1'b0;
    i_ready = 1'b1;
    c = 0;
    while ((fq.size() != 0 || pend.size() != 0) && c < 3000) begin
      step();
      c++;
    end
    n_cmp++;
    if (fq.size() != 0 || pend.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: fifo=%0d outstanding=%0d, required 0/0", fq.size(), pend.size());
    end
    repeat (2) step();
  endtask

  task automatic test_reset_midstream();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    repeat (5) step();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 8'hC0) begin
      n_err++;
      $display("FAIL midrst_setup: valid=%0b data=%02h, required 1/C0", o_valid, o_data);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_fifo_rd_en, o_valid, o_data, o_last} !== '0) begin
      n_err++;
      $display("FAIL midrst_out: rd_en=%0b valid=%0b data=%02h last=%0b, required all 0",
               o_fifo_rd_en, o_valid, o_data, o_last);
    end
    fq.delete();
    pend.delete();
    fifo_empty = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_fifo_rd_en !== 1'b0 || o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_idle: rd_en=%0b valid=%0b, required 0/0", o_fifo_rd_en, o_valid);
      end
    end
    step();
    push(8'h5A);
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 8'h5A) begin
      n_err++;
      $display("FAIL midrst_resume: valid=%0b data=%02h, required 1/5A", o_valid, o_data);
    end
    step();
    i_ready = 1'b1;
    repeat (3) step();
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    int t, got;
    i_ready = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    for (int i = 0; i < 20; i++) push(8'(i));
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!o_valid && t < 10);
    repeat (6) @(negedge i_clk);
    step();
    i_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 20; c++) begin
      @(negedge i_clk);
      if (o_valid && i_ready) got++;
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_word_cnt !== 32'd20 || o_stall_cnt !== 16'd7) begin
      n_err++;
      $display("FAIL stats: word_cnt=%0d stall_cnt=%0d, required 20/7", o_word_cnt, o_stall_cnt);
    end
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_word_cnt !== 32'd0 || o_stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL stats_flush: word_cnt=%0d stall_cnt=%0d, required 0/0", o_word_cnt, o_stall_cnt);
    end
    step();
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_empty_edge();
    test_flush();
    test_random();
    test_reset_midstream();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
